// File: rtl/carry_select_subtractor16_pipe.sv
// rtl/carry_select_subtractor16_pipe.sv - two-stage borrow-select 16-bit subtractor with valid/ready stream
module carry_select_subtractor16_pipe #(
    parameter int WIDTH = 16,
    parameter int LOW_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int HI_W = WIDTH - LOW_W;

    logic             s1_valid_q, s1_valid_d;
    logic [LOW_W-1:0] lo_diff_q, lo_diff_d;
    logic             lo_borrow_q, lo_borrow_d;
    logic [HI_W-1:0]  hi0_q, hi0_d, hi1_q, hi1_d;
    logic             bo0_q, bo0_d, bo1_q, bo1_d;
    logic             a_sign_q, a_sign_d, b_sign_q, b_sign_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             s2_adv, in_xfer, s2_load;
    logic [LOW_W:0]   lo_full;
    logic [HI_W:0]    hi0_full, hi1_full;
    logic [HI_W-1:0]  sel_hi;

    always_comb begin
        s2_adv   = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_adv;
        in_xfer  = in_valid && in_ready;
        s2_load  = s1_valid_q && s2_adv;

        // One extra MSB on each difference captures the borrow-out.
        lo_full  = {1'b0, a[LOW_W-1:0]} - {1'b0, b[LOW_W-1:0]} - {{LOW_W{1'b0}}, bin};
        hi0_full = {1'b0, a[WIDTH-1:LOW_W]} - {1'b0, b[WIDTH-1:LOW_W]};
        hi1_full = hi0_full - {{HI_W{1'b0}}, 1'b1};
        sel_hi   = lo_borrow_q ? hi1_q : hi0_q;

        s1_valid_d  = s1_valid_q;
        lo_diff_d   = lo_diff_q;
        lo_borrow_d = lo_borrow_q;
        hi0_d       = hi0_q;
        hi1_d       = hi1_q;
        bo0_d       = bo0_q;
        bo1_d       = bo1_q;
        a_sign_d    = a_sign_q;
        b_sign_d    = b_sign_q;
        if (in_xfer) begin
            s1_valid_d  = 1'b1;
            lo_diff_d   = lo_full[LOW_W-1:0];
            lo_borrow_d = lo_full[LOW_W];
            hi0_d       = hi0_full[HI_W-1:0];
            bo0_d       = hi0_full[HI_W];
            hi1_d       = hi1_full[HI_W-1:0];
            bo1_d       = hi1_full[HI_W];
            a_sign_d    = a[WIDTH-1];
            b_sign_d    = b[WIDTH-1];
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            diff_d      = {sel_hi, lo_diff_q};
            bout_d      = lo_borrow_q ? bo1_q : bo0_q;
            ovf_d       = (a_sign_q != b_sign_q) && (sel_hi[HI_W-1] != a_sign_q);
        end else if (s2_adv) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            lo_diff_q   <= '0;
            lo_borrow_q <= 1'b0;
            hi0_q       <= '0;
            hi1_q       <= '0;
            bo0_q       <= 1'b0;
            bo1_q       <= 1'b0;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            lo_diff_q   <= lo_diff_d;
            lo_borrow_q <= lo_borrow_d;
            hi0_q       <= hi0_d;
            hi1_q       <= hi1_d;
            bo0_q       <= bo0_d;
            bo1_q       <= bo1_d;
            a_sign_q    <= a_sign_d;
            b_sign_q    <= b_sign_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_carry_select_subtractor16_pipe.sv
// tb/tb_carry_select_subtractor16_pipe.sv - randomized scoreboard bench for carry_select_subtractor16_pipe
module tb_carry_select_subtractor16_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [17:0] exp_q[$];

    carry_select_subtractor16_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {bout, ovf, diff}.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        int          d;
        logic [15:0] md;
        logic        mbo;
        logic        mov;
        d   = int'(ma) - int'(mb) - int'(mbin);
        mbo = (d < 0);
        md  = 16'(d & 32'hFFFF);
        mov = (ma[15] != mb[15]) && (md[15] != ma[15]);
        return {mbo, mov, md};
    endfunction

    // Scoreboard: pop before push so a spurious output cannot consume a same-cycle entry.
    always @(negedge clk) begin
        logic [17:0] e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("sb_spurious_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_diff", diff, e[15:0]);
                    check("sb_bout", bout, e[17]);
                    check("sb_ovf", ovf, e[16]);
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a, b, bin));
        end
    end

    // Pipeline empty, out_ready=1, called just after a rising edge.
    task automatic do_vec(input string tag, input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                          input logic [15:0] ed, input logic eb, input logic eo);
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        @(negedge clk);
        check({tag, "_lat_early"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
    endtask

    initial begin
        int stalls;
        int base;
        int t;
        int cnt;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;

        do_vec("v0m1",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        do_vec("v8k_m1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        do_vec("v7f_mf", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        do_vec("vlosel", 16'h1234, 16'h0234, 1'b1, 16'h0FFF, 1'b0, 1'b0);
        do_vec("vwrap",  16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Backpressure: three back-to-back operands against a stalled consumer.
        out_ready = 1'b0;
        a = 16'd1; b = 16'd1; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'd5; b = 16'd2;
        @(posedge clk); #1;
        a = 16'd9; b = 16'd4;
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_hold_diff", diff, 16'h0000);
        check("bp_still_full", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_back", in_ready, 1);
        check("bp_r0_valid", out_valid, 1);
        check("bp_r0", diff, 16'h0000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_r1_valid", out_valid, 1);
        check("bp_r1", diff, 16'h0003);
        @(negedge clk);
        check("bp_r2_valid", out_valid, 1);
        check("bp_r2", diff, 16'h0005);
        @(negedge clk);
        check("bp_drained", out_valid, 0);
        @(posedge clk); #1;

        // Reset while two results are in flight.
        out_ready = 1'b0;
        a = 16'd7; b = 16'd3; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'd8; b = 16'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        check("mid_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_diff", diff, 0);
        exp_q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("mid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("mid_no_stale", cnt, 0);
        @(posedge clk); #1;

        // Sustained streaming, one operand per cycle.
        base = n_out;
        stalls = 0;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("stream_stalls", stalls, 0);
        check("stream_throughput", n_out - base, 998);
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("stream_count", n_out - base, 1000);

        // Random valid/ready with operands churning while idle.
        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("final_q_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("final_idle", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
